// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and helpers for the SRAM slave.
// Holds the transfer/response/size codes, the slave FSM states and the size/alignment decode.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01,
      HRESP_RETRY = 2'b10,
      HRESP_SPLIT = 2'b11
   } hresp_e;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } sram_state_e;

   // Sizes wider than a word, or accesses not aligned to their own size, are refused.
   function automatic logic xfer_illegal(input logic [2:0] size, input logic [1:0] a);
      logic bad;
      case (size)
         HSIZE_BYTE: bad = 1'b0;
         HSIZE_HALF: bad = a[0];
         HSIZE_WORD: bad = (a != 2'b00);
         default:    bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] a);
      logic [3:0] be;
      case (size)
         HSIZE_BYTE: be = 4'b0001 << a;
         HSIZE_HALF: be = a[1] ? 4'b1100 : 4'b0011;
         default:    be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/ahb_sram_bank.sv
// Word-wide storage array: synchronous byte-enabled write, asynchronous read.
// Contents are never reset.
module ahb_sram_bank #(
   parameter int DEPTH = 1024,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with configurable wait states and a two-cycle ERROR response
// for unsupported sizes or misaligned accesses.
module ahb_sram_slave
   import ahb_pkg::*;
#(
   parameter int ADDR_W      = 12,
   parameter int WAIT_STATES = 0
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic [1:0]  HRESP,
   output logic [31:0] HRDATA
);

   // Handshake: an address phase is taken only when HSEL, HREADY and HTRANS[1] are all high
   // at a rising edge; a data phase ends at the first rising edge where HREADY is high.
   sram_state_e       state;
   logic [1:0]        cnt;
   logic [ADDR_W-1:0] addr_q;
   logic              write_q;
   logic [2:0]        size_q;
   logic              hready_q;
   logic [1:0]        hresp_q;
   logic [31:0]       rdata;

   logic accept;
   logic unused;

   assign accept = HSEL && HREADY && HTRANS[1];
   assign unused = ^{HBURST, HADDR[31:ADDR_W], HTRANS[0]};

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state    <= ST_IDLE;
         cnt      <= 2'd0;
         addr_q   <= '0;
         write_q  <= 1'b0;
         size_q   <= HSIZE_BYTE;
         hready_q <= 1'b1;
         hresp_q  <= HRESP_OKAY;
      end else begin
         case (state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
               if (accept) begin
                  addr_q  <= HADDR[ADDR_W-1:0];
                  write_q <= HWRITE;
                  size_q  <= HSIZE;
                  if (xfer_illegal(HSIZE, HADDR[1:0])) begin
                     state    <= ST_ERR1;
                     hready_q <= 1'b0;
                     hresp_q  <= HRESP_ERROR;
                  end else if (WAIT_STATES == 0) begin
                     state    <= ST_DATA;
                     hready_q <= 1'b1;
                     hresp_q  <= HRESP_OKAY;
                  end else begin
                     state    <= ST_WAIT;
                     cnt      <= 2'(WAIT_STATES);
                     hready_q <= 1'b0;
                     hresp_q  <= HRESP_OKAY;
                  end
               end else begin
                  state    <= ST_IDLE;
                  hready_q <= 1'b1;
                  hresp_q  <= HRESP_OKAY;
               end
            end
            ST_WAIT: begin
               if (cnt == 2'd1) begin
                  state    <= ST_DATA;
                  cnt      <= 2'd0;
                  hready_q <= 1'b1;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            ST_ERR1: begin
               state    <= ST_ERR2;
               hready_q <= 1'b1;
               hresp_q  <= HRESP_ERROR;
            end
            default: begin
               state    <= ST_IDLE;
               hready_q <= 1'b1;
               hresp_q  <= HRESP_OKAY;
            end
         endcase
      end
   end

   // The write lands on the edge that closes DATA, so a pipelined read of the same word sees it.
   ahb_sram_bank #(
      .DEPTH(1 << (ADDR_W - 2))
   ) u_bank (
      .clk   (HCLK),
      .we    ((state == ST_DATA) && write_q),
      .be    (byte_lanes(size_q, addr_q[1:0])),
      .addr  (addr_q[ADDR_W-1:2]),
      .wdata (HWDATA),
      .rdata (rdata)
   );

   assign HREADYOUT = hready_q;
   assign HRESP     = hresp_q;
   assign HRDATA    = ((state == ST_DATA) && !write_q) ? rdata : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two instances (0 and 2 wait states) on one shared AHB bus,
// driven by a pipelined master and checked against a byte-level memory model.
module tb_ahb_sram_slave;

   localparam int ADDR_W = 12;
   localparam int WORDS  = 1 << (ADDR_W - 2);

   typedef struct {
      bit          gap;
      bit          busy;
      bit          write;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
   } xfer_t;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // shared bus
   logic        tgt;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [31:0] hwdata;

   logic        hro0, hro2;
   logic [1:0]  hresp0, hresp2;
   logic [31:0] hrdata0, hrdata2;
   logic        hready;
   logic [1:0]  hresp;
   logic [31:0] hrdata;

   assign hready = tgt ? hro2 : hro0;
   assign hresp  = tgt ? hresp2 : hresp0;
   assign hrdata = tgt ? hrdata2 : hrdata0;

   ahb_sram_slave #(.ADDR_W(ADDR_W), .WAIT_STATES(0)) u_dut_ws0 (
      .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel && !tgt), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
      .HREADYOUT(hro0), .HRESP(hresp0), .HRDATA(hrdata0)
   );

   ahb_sram_slave #(.ADDR_W(ADDR_W), .WAIT_STATES(2)) u_dut_ws2 (
      .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel && tgt), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
      .HREADYOUT(hro2), .HRESP(hresp2), .HRDATA(hrdata2)
   );

   // scoreboard and reference memory
   xfer_t       pend[$];
   logic [31:0] exp_q[$];
   logic [31:0] ref_mem [2][WORDS];
   int passed = 0;
   int fails  = 0;
   int total  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit ref_illegal(input logic [2:0] size, input logic [31:0] addr);
      if (size > 3'd2) return 1'b1;
      return (addr % (32'd1 << size)) != 0;
   endfunction

   // driver tasks
   task automatic queue_xfer(input bit write, input logic [31:0] addr, input logic [2:0] size,
                             input logic [31:0] wdata);
      xfer_t x;
      int    word;
      int    lane;
      x.gap = 1'b0; x.busy = 1'b0; x.write = write; x.addr = addr; x.size = size; x.wdata = wdata;
      pend.push_back(x);
      word = int'((addr % (32'd1 << ADDR_W)) / 4);
      if (!ref_illegal(size, addr)) begin
         if (write) begin
            for (int b = 0; b < (1 << size); b++) begin
               lane = int'(addr % 4) + b;
               ref_mem[tgt][word][lane*8 +: 8] = wdata[lane*8 +: 8];
            end
         end else begin
            exp_q.push_back(ref_mem[tgt][word]);
         end
      end
   endtask

   task automatic queue_gap(input bit busy);
      xfer_t x;
      x.gap = 1'b1; x.busy = busy; x.write = 1'b0; x.addr = $urandom; x.size = 3'd2; x.wdata = '0;
      pend.push_back(x);
   endtask

   task automatic complete(input xfer_t dp, input int waits, input logic [1:0] wait_resp,
                           input bit wait_bad);
      bit legal;
      bit bad;
      int exp_waits;
      legal = !dp.gap && !ref_illegal(dp.size, dp.addr);
      bad   = !dp.gap && !legal;
      exp_waits = legal ? (tgt ? 2 : 0) : (bad ? 1 : 0);
      check("wait_cycles", 32'(waits), 32'(exp_waits));
      check("wait_resp", {30'd0, wait_resp}, bad ? 32'd1 : 32'd0);
      check("wait_rdata_zero", {31'd0, wait_bad}, 32'd0);
      check("final_resp", {30'd0, hresp}, bad ? 32'd1 : 32'd0);
      if (legal && !dp.write) check("rdata", hrdata, exp_q.pop_front());
      else check("rdata_zero", hrdata, 32'd0);
   endtask

   // Runs every queued transfer on the current target; call just after a rising edge.
   task automatic run_seq();
      xfer_t      dp;
      bit         dp_v = 1'b0;
      int         waits = 0;
      logic [1:0] wait_resp = 2'b00;
      bit         wait_bad = 1'b0;
      int         budget = 0;
      while ((pend.size() > 0 || dp_v) && budget < 20000) begin
         budget++;
         hburst = 3'($urandom_range(0, 7));
         if (pend.size() > 0) begin
            hsel   = 1'b1;
            haddr  = pend[0].addr;
            hwrite = pend[0].write;
            hsize  = pend[0].size;
            if (pend[0].gap) htrans = pend[0].busy ? 2'b01 : 2'b00;
            else htrans = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11;
         end else begin
            hsel   = ($urandom_range(0, 1) != 0);
            htrans = 2'b00;
         end
         hwdata = (dp_v && dp.write) ? dp.wdata : $urandom;
         @(negedge clk);
         if (dp_v) begin
            if (!hready) begin
               waits++;
               wait_resp = wait_resp | hresp;
               if (hrdata !== 32'd0) wait_bad = 1'b1;
            end else begin
               complete(dp, waits, wait_resp, wait_bad);
               dp_v = 1'b0;
            end
         end
         if (hready && pend.size() > 0) begin
            dp = pend.pop_front();
            dp_v = 1'b1; waits = 0; wait_resp = 2'b00; wait_bad = 1'b0;
         end
         @(posedge clk); #1;
      end
      check("seq_budget", {31'd0, budget < 20000}, 32'd1);
      pend.delete();
      hsel = 1'b0;
      htrans = 2'b00;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int          r;
      tgt = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
      hsize = 3'd0; hburst = 3'd0; hwdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_hreadyout0", {31'd0, hro0}, 32'd1);
      check("reset_hreadyout2", {31'd0, hro2}, 32'd1);
      check("reset_hresp0", {30'd0, hresp0}, 32'd0);
      check("reset_hresp2", {30'd0, hresp2}, 32'd0);
      check("reset_hrdata0", hrdata0, 32'd0);
      check("reset_hrdata2", hrdata2, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // fill both memories so the model starts from known contents
      for (int t = 0; t < 2; t++) begin
         tgt = t[0];
         for (int w = 0; w < WORDS; w++) queue_xfer(1'b1, 32'(w * 4), 3'd2, $urandom);
         run_seq();
      end

      // directed, zero wait states
      tgt = 1'b0;
      queue_xfer(1'b1, 32'h004, 3'd2, 32'hDEADBEEF);
      queue_xfer(1'b0, 32'h004, 3'd2, 32'h0);
      queue_xfer(1'b1, 32'h008, 3'd2, 32'h0);
      queue_xfer(1'b1, 32'h008, 3'd0, 32'h0000_0011);
      queue_xfer(1'b1, 32'h00B, 3'd0, 32'h2200_0000);
      queue_xfer(1'b0, 32'h008, 3'd2, 32'h0);
      queue_xfer(1'b1, 32'h006, 3'd2, 32'h1234_5678);
      queue_xfer(1'b0, 32'h004, 3'd2, 32'h0);
      queue_xfer(1'b1, 32'h00C, 3'd1, 32'hBEEF_0000 | 32'h0000_CAFE);
      queue_xfer(1'b1, 32'h00E, 3'd1, 32'h5A5A_0000);
      queue_xfer(1'b0, 32'h00C, 3'd2, 32'h0);
      queue_xfer(1'b0, 32'h00D, 3'd1, 32'h0);
      queue_xfer(1'b0, 32'h00C, 3'd3, 32'h0);
      run_seq();

      // directed, two wait states
      tgt = 1'b1;
      queue_xfer(1'b1, 32'h004, 3'd2, 32'hCAFE_F00D);
      queue_xfer(1'b0, 32'h004, 3'd2, 32'h0);
      queue_xfer(1'b1, 32'h00A, 3'd2, 32'h0);
      queue_xfer(1'b0, 32'h008, 3'd2, 32'h0);
      run_seq();

      // random traffic on both targets, with aliased upper address bits and idle/busy gaps
      for (int t = 0; t < 2; t++) begin
         tgt = t[0];
         for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 9));
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            if (r == 0) queue_gap($urandom_range(0, 1) != 0);
            else if (r == 1) queue_xfer($urandom_range(0, 1) != 0, a, 3'($urandom_range(3, 7)), $urandom);
            else queue_xfer($urandom_range(0, 1) != 0, a, 3'($urandom_range(0, 2)), $urandom);
         end
         run_seq();
      end

      // reset during the wait phase of a write must leave the word untouched
      tgt = 1'b1;
      hsel = 1'b1; haddr = 32'h010; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
      @(posedge clk); #1;
      hsel = 1'b0; htrans = 2'b00; hwdata = 32'hA5A5_A5A5;
      @(negedge clk);
      check("rst_pre_in_wait", {31'd0, hready}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_hreadyout", {31'd0, hro2}, 32'd1);
      check("rst_mid_hresp", {30'd0, hresp2}, 32'd0);
      check("rst_mid_hrdata", hrdata2, 32'd0);
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      queue_xfer(1'b0, 32'h010, 3'd2, 32'h0);
      queue_xfer(1'b0, 32'h004, 3'd2, 32'h0);
      run_seq();
      tgt = 1'b0;
      queue_xfer(1'b0, 32'h004, 3'd2, 32'h0);
      run_seq();

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB slave responder placed behind the system address decoder; it answers whichever HSELx region it is wired to.
- It is a word-organised on-chip SRAM with configurable wait states and byte/halfword/word access.
- It returns the two-cycle ERROR response for illegal transfers.
- It is the standard memory target for slaves 1-6 in the system memory map.

Parameters:
- ADDR_W, 12, byte-offset bits decoded locally; memory depth = 2^(ADDR_W-2) 32-bit words.
- WAIT_STATES, 0, wait cycles inserted in every OKAY data phase; legal range 0..3.

Ports:
- HCLK  input  1  bus clock; all state changes on the rising edge.
- HRESETn  input  1  asynchronous, active-low reset.
- HSEL  input  1  slave select from the address decoder.
- HADDR  input  32  address; only [ADDR_W-1:0] used, upper bits alias.
- HTRANS  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  input  1  1 = write.
- HSIZE  input  3  000 byte, 001 halfword, 010 word; others illegal.
- HBURST  input  3  accepted, ignored; each beat is handled independently.
- HWDATA  input  32  write data, valid in the data phase.
- HREADY  input  1  bus-level ready (muxed HREADYOUT of the data-phase slave).
- HREADYOUT  output  1  this slave's ready.
- HRESP  output  2  00 OKAY, 01 ERROR.
- HRDATA  output  32  read data.

Behaviour:
- Reset (async assert, sync release): state IDLE, HREADYOUT=1, HRESP=00, HRDATA=0, wait counter 0. Memory contents are not reset.
- Transfer acceptance: an address phase is accepted on a rising edge with HSEL=1, HREADY=1 and HTRANS[1]=1.
  - On acceptance, register HADDR[ADDR_W-1:0], HWRITE and HSIZE.
  - If HSEL=1 and HREADY=1 but HTRANS is IDLE or BUSY, the next cycle is an OKAY zero-wait response with no access.
- Illegal transfer, checked at acceptance: HSIZE>2, halfword with addr[0]=1, or word with addr[1:0]!=0.
- States:
  - IDLE: HREADYOUT=1, HRESP=OKAY.
    - Legal accept with WAIT_STATES=0 -> DATA.
    - Legal accept with WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES.
    - Illegal accept -> ERR1.
  - WAIT: HREADYOUT=0, HRESP=OKAY. Counter decrements each cycle; at 1 -> DATA.
  - DATA: HREADYOUT=1, HRESP=OKAY. This is the final data-phase cycle.
    - Write: commit HWDATA byte lanes selected by size and address to the memory at the closing edge.
    - Read: HRDATA = addressed word, all 32 bits driven; unused lanes still carry memory contents.
    - A new transfer accepted in the same cycle (pipelined) -> DATA / WAIT / ERR1 as from IDLE; otherwise -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=ERROR -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=ERROR, no memory access.
    - Accepts a new transfer like DATA; otherwise -> IDLE.
    - If the master drives HTRANS=IDLE here, it is treated as a plain IDLE.
- HRDATA is 0 in every cycle that is not a read DATA cycle.
- Latency: a read with WAIT_STATES=N completes N+1 cycles after acceptance. ERROR always takes 2 cycles.
- Write-then-read of the same address back-to-back returns the new data, because the write commits at the edge that starts the read data phase.
- HSEL deasserting during WAIT does not abort the transfer; the data phase always completes.
- Reset mid-transfer: the transfer is abandoned, outputs return to reset values immediately, and no partial write occurs.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS codes IDLE/BUSY/NONSEQ/SEQ.
  - HRESP codes OKAY/ERROR/RETRY/SPLIT.
  - HSIZE codes BYTE/HALF/WORD.
  - State enum for this block.
- Sub-module ahb_sram_bank: synchronous-write, asynchronous-read 32-bit memory with 4-bit byte enable, parameterised on depth. All protocol logic stays in ahb_sram_slave.

Test Plan:
- Word write 0xDEADBEEF to 0x004, then word read 0x004, WAIT_STATES=0 -> HRDATA=0xDEADBEEF in the read data phase; HREADYOUT never low.
- Byte writes 0x11 to 0x008 and 0x22 to 0x00B over a word previously 0 -> word read of 0x008 = 0x22000011.
- WAIT_STATES=2, word read -> HREADYOUT low for exactly 2 cycles, then high with valid data; 3 cycles from accept to completion.
- Word write to 0x006 (misaligned) -> HRESP=01 with HREADYOUT=0, then HRESP=01 with HREADYOUT=1; a following read of 0x004 shows the word unchanged.
- Back-to-back NONSEQ write then read of the same address, pipelined -> the read returns the written value; no idle cycle inserted.
- HRESETn pulsed low during WAIT of a write -> HREADYOUT=1, HRESP=00, HRDATA=0 immediately; the target word is unchanged after reset release.
